// File: rtl/avalon_ram_pkg.sv
// Shared types and elaboration-time parameter checks for the pipelined Avalon-MM on-chip RAM.
package avalon_ram_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int MAX_READ_LATENCY = 2;

  function automatic bit params_ok(input int data_w, input int addr_w,
                                   input int depth, input int read_latency);
    return (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY) &&
           (data_w > 0) && (data_w % 8 == 0) && (depth >= 1) &&
           (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/avalon_ram_core.sv
// Byte-enabled synchronous single-port RAM with a registered read port.
// A read in the same cycle as a write to that word returns the old contents.
module avalon_ram_core
  import avalon_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Preload image is attached through the vendor memory-init attribute.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (ce && we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Only updates on a read so the value holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (ce && re) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/avalon_onchip_ram_pipe.sv
// Avalon-MM pipelined on-chip RAM slave: zero-fill after reset, then byte-enabled
// writes and reads answered READ_LATENCY enabled cycles later via readdatavalid.
module avalon_onchip_ram_pipe
  import avalon_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 10,
  parameter int    DEPTH          = 1024,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output state_t              fsm_state
);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, READ_LATENCY)) begin : g_bad_params
    $error("avalon_onchip_ram_pipe: illegal DATA_W/ADDR_W/DEPTH/READ_LATENCY");
  end

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              clearing, wr_acc, rd_acc, v1, last_v;
  logic [DATA_W-1:0] core_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RST;
      clr_cnt <= '0;
    end else if (clken) begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      RST: begin
        clr_cnt_nxt = '0;
        state_nxt   = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      end
      CLEAR: begin
        if (clr_cnt == LAST_WORD) state_nxt = READY;
        else                      clr_cnt_nxt = clr_cnt + 1'b1;
      end
      READY:   state_nxt = READY;
      default: state_nxt = RST;
    endcase
  end

  // Avalon handshake: a transfer is taken on an enabled edge where chipselect and
  // read or write are high and waitrequest is low; every taken read yields exactly
  // one readdatavalid strobe, in order, READ_LATENCY enabled edges later.
  assign waitrequest = (state != READY) | ~clken;
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign clearing    = (state == CLEAR);
  assign fsm_state   = state;

  avalon_ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_FILE((CLEAR_ON_RESET != 0) ? "" : INIT_FILE)
  ) u_core (
    .clk  (clk),
    .rst_n(reset_n),
    .ce   (clken),
    .addr (clearing ? clr_cnt : address),
    .we   (clearing | wr_acc),
    .be   (clearing ? {(DATA_W/8){1'b1}} : byteenable),
    .wdata(clearing ? {DATA_W{1'b0}} : writedata),
    .re   (rd_acc),
    .rdata(core_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   v1 <= 1'b0;
    else if (clken) v1 <= rd_acc;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (clken) begin
        v2 <= v1;
        if (v1) d2 <= core_rdata;
      end
    end
    assign readdata = d2;
    assign last_v   = v2;
  end else begin : g_lat1
    assign readdata = core_rdata;
    assign last_v   = v1;
  end

  // Gating with clken keeps a frozen response from being reported twice.
  assign readdatavalid = last_v & clken;

endmodule

// File: tb/tb_avalon_onchip_ram_pipe.sv
// Bench for avalon_onchip_ram_pipe: latency-1 and latency-2 instances share stimulus
// and are checked every cycle against a word-level memory/response model.
module tb_avalon_onchip_ram_pipe;
  import avalon_ram_pkg::*;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int DEPTH    = 16;
  localparam int READY_AT = DEPTH + 1;

  logic            clk = 1'b0;
  logic            reset_n, clken, chipselect, read, write;
  logic [AW-1:0]   address;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   writedata;
  logic [DW-1:0]   rd1, rd2;
  logic            rdv1, rdv2, wr1, wr2;
  state_t          st1, st2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avalon_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
                           .CLEAR_ON_RESET(1), .INIT_FILE("")) u_l1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(rd1), .readdatavalid(rdv1),
    .waitrequest(wr1), .fsm_state(st1));

  avalon_onchip_ram_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
                           .CLEAR_ON_RESET(1), .INIT_FILE("")) u_l2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(rd2), .readdatavalid(rdv2),
    .waitrequest(wr2), .fsm_state(st2));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            stamp_q[$];
  int            head[2];
  int            ecnt = 0;
  bit            mdl_rdy;

  function automatic logic [DW-1:0] mdl_read(input int a);
    return (a < DEPTH) ? mdl_mem[a] : '0;
  endfunction

  // Response k (latency k+1) is on the bus once latency enabled edges have passed.
  function automatic bit resp_due(input int k);
    return (head[k] < exp_q.size()) && (stamp_q[head[k]] + k + 1 <= ecnt);
  endfunction

  initial begin
    head[0] = 0;
    head[1] = 0;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      head[0] = exp_q.size();
      head[1] = exp_q.size();
      ecnt    = 0;
    end else if (clken) begin
      mdl_rdy = (ecnt >= READY_AT);
      for (int k = 0; k < 2; k++) if (resp_due(k)) head[k]++;
      if (mdl_rdy && chipselect) begin
        if (write) begin
          if (int'(address) < DEPTH)
            for (int b = 0; b < DW/8; b++)
              if (byteenable[b]) mdl_mem[int'(address)][8*b +: 8] = writedata[8*b +: 8];
        end else if (read) begin
          exp_q.push_back(mdl_read(int'(address)));
          stamp_q.push_back(ecnt);
        end
      end
      ecnt++;
      if (ecnt == READY_AT) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    end
  end

  always @(negedge clk) begin
    bit exp_wr, ev1, ev2;
    exp_wr = !reset_n || (ecnt < READY_AT) || !clken;
    ev1    = reset_n && clken && resp_due(0);
    ev2    = reset_n && clken && resp_due(1);
    chk("wait_l1", wr1, exp_wr);
    chk("wait_l2", wr2, exp_wr);
    chk("rdv_l1", rdv1, ev1);
    chk("rdv_l2", rdv2, ev2);
    if (ev1) chk("data_l1", rd1, exp_q[head[0]]);
    if (ev2) chk("data_l2", rd2, exp_q[head[1]]);
  end

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic idle();
    chipselect = 0; read = 0; write = 0;
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    #1;
    chipselect = 1; write = 1; read = 0; address = a; writedata = d; byteenable = be;
    @(posedge clk); #1 idle();
    @(negedge clk);
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] e);
    #1;
    chipselect = 1; read = 1; write = 0; address = a;
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("dir_rdv_l1", rdv1, 1'b1);
    chk("dir_data_l1", rd1, e);
    chk("dir_early_l2", rdv2, 1'b0);
    @(negedge clk);
    chk("dir_rdv_l2", rdv2, 1'b1);
    chk("dir_data_l2", rd2, e);
    chk("dir_once_l1", rdv1, 1'b0);
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) chk({nm, "_state"}, 32'(st1), 32'(CLEAR));
    end while (wr1 && n < 100);
    chk(nm, n, DEPTH + 1);
    chk({nm, "_ready"}, 32'(st2), 32'(READY));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_n = 0; clken = 1; idle(); address = '0; byteenable = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_l1", rd1, '0);
    chk("rst_data_l2", rd2, '0);
    chk("rst_state", 32'(st1), 32'(RST));
    #1 reset_n = 1;
    wait_clear("clear_cycles");
    for (int a = 0; a < DEPTH; a++) rd_chk(AW'(a), '0);

    wr_op(5, 32'hDEADBEEF, 4'hF);
    wr_op(5, 32'h0000_1200, 4'b0010);
    chk("model_pin_be", mdl_read(5), 32'hDEAD12EF);
    rd_chk(5, 32'hDEAD12EF);
    wr_op(5, 32'hFFFF_FFFF, 4'b0000);
    rd_chk(5, 32'hDEAD12EF);
    wr_op(20, 32'h5555_5555, 4'hF);
    rd_chk(20, '0);
    rd_chk(4, '0);

    for (int i = 0; i < 4; i++) wr_op(AW'(i), 32'hA0 + i, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) begin chipselect = 1; read = 1; address = AW'(i); end
      else idle();
      @(posedge clk); @(negedge clk);
      chk("b2b_rdv_l1", rdv1, i < 4);
      if (i < 4) chk("b2b_data_l1", rd1, 32'hA0 + i);
      chk("b2b_rdv_l2", rdv2, i >= 1);
      if (i >= 1) chk("b2b_data_l2", rd2, 32'hA0 + i - 1);
    end

    wr_op(7, 32'h11, 4'hF);
    #1 chipselect = 1; read = 1; write = 1; address = 7; writedata = 32'h22; byteenable = 4'hF;
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("rw_drop_l1", rdv1, 1'b0);
    chk("rw_drop_l2", rdv2, 1'b0);
    @(negedge clk);
    chk("rw_drop_l2b", rdv2, 1'b0);
    chk("model_pin_rw", mdl_read(7), 32'h22);
    rd_chk(7, 32'h22);

    wr_op(9, 32'h99, 4'hF);
    #1 chipselect = 1; read = 1; address = 9;
    @(posedge clk); #1 idle(); clken = 0;
    repeat (3) begin
      @(negedge clk);
      chk("ce_hold_l1", rdv1, 1'b0);
      chk("ce_hold_l2", rdv2, 1'b0);
    end
    #1 clken = 1;
    #1 chk("ce_resume_l1", rdv1, 1'b1);
    chk("ce_data_l1", rd1, 32'h99);
    @(negedge clk);
    chk("ce_once_l1", rdv1, 1'b0);
    chk("ce_resume_l2", rdv2, 1'b1);
    chk("ce_data_l2", rd2, 32'h99);
    @(negedge clk);
    chk("ce_once_l2", rdv2, 1'b0);

    #1 chipselect = 1; read = 1; address = 9;
    @(posedge clk); #1 idle(); reset_n = 0;
    #1 chk("rst_flush_l1", rdv1, 1'b0);
    chk("rst_flush_l2", rdv2, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_l2", rdv2, 1'b0);
      chk("rst_wait", wr2, 1'b1);
      chk("rst_state_l2", 32'(st2), 32'(RST));
    end
    #1 reset_n = 1;
    repeat (6) @(posedge clk);
    @(negedge clk); #1 reset_n = 0;
    @(negedge clk);
    chk("midclr_state", 32'(st1), 32'(RST));
    #1 reset_n = 1;
    wait_clear("reclear_cycles");
    rd_chk(9, '0);
    rd_chk(15, '0);

    for (int c = 0; c < 1500; c++) begin
      int op;
      @(negedge clk); #1;
      reset_n    = !(c >= 700 && c < 703);
      clken      = ($urandom_range(0, 9) != 0);
      chipselect = ($urandom_range(0, 7) != 0);
      op         = $urandom_range(0, 9);
      read       = (op < 5) || (op == 9);
      write      = (op >= 5);
      address    = AW'($urandom_range(0, 19));
      byteenable = 4'($urandom_range(0, 15));
      writedata  = $urandom;
    end
    @(negedge clk); #1 idle(); clken = 1;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
